sim_stop_monitor: RTL
=====================

SIM_STOP_MONITOR -- requirements
Module: sim_stop_monitor

Interface
REQ-001 SHALL have parameter STATE_W, default 3, width of the watched processing-unit state.
REQ-002 SHALL have parameter N_ACT, default 2, number of activity channels (e.g. input/output active).
REQ-003 SHALL have parameter CNT_W, default 8, idle counter width.
REQ-004 SHALL have parameter IDLE_CYCLES, default 255, stable-state cycles required before stop; legal range 1..2^CNT_W-1.
REQ-005 SHALL have parameter WDOG_W, default 32, run-cycle counter width.
REQ-006 SHALL have parameter WDOG_LIMIT, default 0, run cycles before timeout; 0 disables timeout.
REQ-007 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-008 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-009 SHALL have port state_in  input  STATE_W  watched machine state.
REQ-010 SHALL have port active_in  input  N_ACT  per-channel busy flags.
REQ-011 SHALL have port active_mask  input  N_ACT  1 = channel participates in busy.
REQ-012 SHALL have port clear  input  1  single-cycle rearm from STOPPED/TIMEOUT.
REQ-013 SHALL have port machine_is_stop  output  1  high while FSM in STOPPED.
REQ-014 SHALL have port stop_pulse  output  1  one-cycle pulse on each RUN->STOPPED entry.
REQ-015 SHALL have port timeout  output  1  high while FSM in TIMEOUT.
REQ-016 SHALL have port stop_state  output  STATE_W  state_in value captured at stop entry.
REQ-017 SHALL have port idle_count  output  CNT_W  current stable-state counter.
REQ-018 SHALL have port run_cycles  output  WDOG_W  cycles spent in RUN since reset/clear.
REQ-019 SHALL have port stop_count  output  8  number of RUN->STOPPED entries.

Function
REQ-020 SHALL register last_state <= state_in every cycle, including during reset; changed = (state_in != last_state).
REQ-021 SHALL define busy = |(active_in & active_mask), combinational.
REQ-022 SHALL update idle_count: changed -> 0; else if idle_count != IDLE_CYCLES -> +1; else hold (saturate at IDLE_CYCLES, never wrap).
REQ-023 SHALL define stop_cond = (idle_count == IDLE_CYCLES) && !busy && !changed.
REQ-024 SHALL implement FSM states RUN, STOPPED, TIMEOUT.
REQ-025 SHALL in RUN: stop_cond -> STOPPED; else WDOG_LIMIT != 0 and run_cycles == WDOG_LIMIT-1 -> TIMEOUT; else stay; stop_cond has priority on same cycle.
REQ-026 SHALL in STOPPED: clear -> RUN; else changed or busy -> RUN (machine resumed); else stay.
REQ-027 SHALL in TIMEOUT: stay until clear (-> RUN) or reset; state/activity ignored.
REQ-028 SHALL on clear (any FSM state): zero idle_count and run_cycles the following cycle; clear in RUN only performs the zeroing.
REQ-029 SHALL increment run_cycles once per cycle in RUN, saturating at 2^WDOG_W-1.
REQ-030 SHALL register all outputs: stop_cond sampled at edge N -> machine_is_stop and stop_pulse high after edge N+1... i.e. visible in cycle N+1.
REQ-031 SHALL capture stop_state <= state_in and increment stop_count (saturating at 255) on the same edge as RUN->STOPPED.
REQ-032 SHALL deassert stop_pulse after exactly one cycle; back-to-back stops need at least one RUN cycle in between.
REQ-033 SHALL treat active_mask = 0 as never busy.

Reset
REQ-034 SHALL on reset force FSM to RUN, idle_count 0, run_cycles 0, stop_count 0, stop_state 0, machine_is_stop 0, stop_pulse 0, timeout 0.
REQ-035 SHALL let reset asserted mid-STOPPED or mid-TIMEOUT take effect on the next edge, overriding clear and all transitions.

Verification
REQ-036 SHALL cover: IDLE_CYCLES=4, state_in constant 3, active_in=0 -> idle_count 1,2,3,4; machine_is_stop and stop_pulse rise one cycle after idle_count reaches 4; stop_state=3, stop_count=1.
REQ-037 SHALL cover: state_in toggles every 3 cycles, IDLE_CYCLES=4 -> idle_count never exceeds 2, machine_is_stop stays 0.
REQ-038 SHALL cover: stable state, active_in=2'b01, mask=2'b01 -> no stop; mask changed to 2'b00 -> stop one cycle after next stop_cond.
REQ-039 SHALL cover: WDOG_LIMIT=10, state toggling every cycle -> timeout high after run_cycles reaches 9; clear -> RUN, run_cycles 0, timeout 0.
REQ-040 SHALL cover: in STOPPED, state_in changes 3->5 -> machine_is_stop falls next cycle, idle_count 0; restabilise -> second stop_pulse, stop_count=2, stop_state=5.
REQ-041 SHALL cover: reset pulsed while TIMEOUT with clear also high -> all outputs zero next cycle, FSM RUN.

Source files
------------

// File: rtl/sim_stop_monitor.sv
`default_nettype none
// ============================================================================
// Module : sim_stop_monitor
// Flags when a watched machine has settled (stable state, no activity) and
// raises a watchdog timeout when it runs too long without settling.
// Rev    : 1.0
// ============================================================================
module sim_stop_monitor #(
  parameter int STATE_W     = 3,
  parameter int N_ACT       = 2,
  parameter int CNT_W       = 8,
  parameter int IDLE_CYCLES = 255,
  parameter int WDOG_W      = 32,
  parameter int WDOG_LIMIT  = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [STATE_W-1:0] state_in,
  input  logic [N_ACT-1:0]   active_in,
  input  logic [N_ACT-1:0]   active_mask,
  input  logic               clear,
  output logic               machine_is_stop,
  output logic               stop_pulse,
  output logic               timeout,
  output logic [STATE_W-1:0] stop_state,
  output logic [CNT_W-1:0]   idle_count,
  output logic [WDOG_W-1:0]  run_cycles,
  output logic [7:0]         stop_count
);

  localparam logic [1:0] c_st_run     = 2'd0;
  localparam logic [1:0] c_st_stopped = 2'd1;
  localparam logic [1:0] c_st_timeout = 2'd2;

  localparam logic [CNT_W-1:0]  c_idle_max  = CNT_W'(IDLE_CYCLES);
  localparam logic [WDOG_W-1:0] c_run_max   = '1;
  localparam logic [WDOG_W-1:0] c_wdog_last = WDOG_W'((WDOG_LIMIT > 0) ? (WDOG_LIMIT - 1) : 0);
  localparam logic              c_wdog_en   = (WDOG_LIMIT != 0);
  localparam logic [7:0]        c_cnt_max   = 8'hFF;

  logic [1:0]         state_q, state_d;
  logic [STATE_W-1:0] last_state_q;
  logic [CNT_W-1:0]   idle_count_q, idle_count_d;
  logic [WDOG_W-1:0]  run_cycles_q, run_cycles_d;
  logic [STATE_W-1:0] stop_state_q, stop_state_d;
  logic [7:0]         stop_count_q, stop_count_d;
  logic               machine_is_stop_q, machine_is_stop_d;
  logic               stop_pulse_q, stop_pulse_d;
  logic               timeout_q, timeout_d;

  logic changed;
  logic busy;
  logic stop_cond;
  logic stop_entry;

  // Tracks state_in even through reset so "changed" is meaningful on the
  // very first cycle after reset releases.
  always_ff @(posedge clk) begin
    last_state_q <= state_in;
  end

  always_comb begin
    changed   = (state_in != last_state_q);
    busy      = |(active_in & active_mask);
    stop_cond = (idle_count_q == c_idle_max) && !busy && !changed;
  end

  always_comb begin
    idle_count_d = idle_count_q;
    if (clear || changed) begin
      idle_count_d = '0;
    end else if (idle_count_q != c_idle_max) begin
      idle_count_d = idle_count_q + 1'b1;
    end
  end

  always_comb begin
    run_cycles_d = run_cycles_q;
    if (clear) begin
      run_cycles_d = '0;
    end else if ((state_q == c_st_run) && (run_cycles_q != c_run_max)) begin
      run_cycles_d = run_cycles_q + 1'b1;
    end
  end

  // Next-state logic; a settled machine wins over a simultaneous watchdog hit.
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_st_run: begin
        if (stop_cond) begin
          state_d = c_st_stopped;
        end else if (c_wdog_en && (run_cycles_q == c_wdog_last)) begin
          state_d = c_st_timeout;
        end
      end
      c_st_stopped: begin
        if (clear || changed || busy) begin
          state_d = c_st_run;
        end
      end
      c_st_timeout: begin
        if (clear) begin
          state_d = c_st_run;
        end
      end
      default: begin
        state_d = c_st_run;
      end
    endcase
  end

  always_comb begin
    stop_entry        = (state_q == c_st_run) && (state_d == c_st_stopped);
    machine_is_stop_d = (state_d == c_st_stopped);
    timeout_d         = (state_d == c_st_timeout);
    stop_pulse_d      = stop_entry;
    stop_state_d      = stop_state_q;
    stop_count_d      = stop_count_q;
    if (stop_entry) begin
      stop_state_d = state_in;
      if (stop_count_q != c_cnt_max) begin
        stop_count_d = stop_count_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q           <= c_st_run;
      idle_count_q      <= '0;
      run_cycles_q      <= '0;
      stop_state_q      <= '0;
      stop_count_q      <= '0;
      machine_is_stop_q <= 1'b0;
      stop_pulse_q      <= 1'b0;
      timeout_q         <= 1'b0;
    end else begin
      state_q           <= state_d;
      idle_count_q      <= idle_count_d;
      run_cycles_q      <= run_cycles_d;
      stop_state_q      <= stop_state_d;
      stop_count_q      <= stop_count_d;
      machine_is_stop_q <= machine_is_stop_d;
      stop_pulse_q      <= stop_pulse_d;
      timeout_q         <= timeout_d;
    end
  end

  assign machine_is_stop = machine_is_stop_q;
  assign stop_pulse      = stop_pulse_q;
  assign timeout         = timeout_q;
  assign stop_state      = stop_state_q;
  assign idle_count      = idle_count_q;
  assign run_cycles      = run_cycles_q;
  assign stop_count      = stop_count_q;

endmodule
`default_nettype wire
